tag_mem_port_ctrl: RTL and testbench

// Initiator-side controller for the byte-granular tag RAM (1 tag bit per byte, per-byte read-back).

---
 rtl/tag_mem_port_ctrl.sv | 174 +++++++++++++++++
 tb/tb_tag_mem_port_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tag_mem_port_ctrl
// Description : Core-side tag access port and range-clear engine for a
//               byte-granular tag RAM (one tag bit per byte).
// Revision    : 1.0
// ============================================================================
module tag_mem_port_ctrl #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 15
) (
   input  logic                    clk,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic                    wdata_i,
   output logic                    rvalid_o,
   output logic                    rdata_o,
   output logic [DATA_WIDTH/8-1:0] rdata_be_o,
   input  logic                    clr_start_i,
   input  logic [ADDR_WIDTH-1:0]   clr_base_i,
   input  logic [CNT_WIDTH-1:0]    clr_words_i,
   output logic                    clr_busy_o,
   output logic                    clr_done_o,
   output logic                    ram_en_o,
   output logic                    ram_we_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic                    ram_wdata_o,
   input  logic [DATA_WIDTH/8-1:0] ram_rdata_i
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int WA_W  = ADDR_WIDTH - OFF_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  words_q, words_d;
   logic [WA_W-1:0]       base_q, base_d;
   logic                  pend_q, pend_d;
   logic                  we_q, we_d;
   logic [BE_W-1:0]       be_q, be_d;
   logic [BE_W-1:0]       hold_be_q, hold_be_d;
   logic                  hold_bit_q, hold_bit_d;

   logic                  gnt;
   logic [BE_W-1:0]       resp_be;
   logic [WA_W-1:0]       cnt_word;
   logic [WA_W-1:0]       clr_word;
   logic                  unused_base_bits;

   // Byte offset bits of the clear base are meaningless for a word-wise clear.
   assign unused_base_bits = ^clr_base_i[OFF_W-1:0];

   generate
      if (CNT_WIDTH >= WA_W) begin : g_cnt_trunc
         assign cnt_word = cnt_q[WA_W-1:0];
      end else begin : g_cnt_ext
         assign cnt_word = {{(WA_W-CNT_WIDTH){1'b0}}, cnt_q};
      end
   endgenerate

   // Word address arithmetic is WA_W bits wide, so it wraps at the top of memory.
   assign clr_word = base_q + cnt_word;

   assign gnt     = (state_q == IDLE) && req_i && !clr_start_i;
   assign resp_be = we_q ? '0 : (ram_rdata_i & be_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      words_d    = words_q;
      base_d     = base_q;
      pend_d     = gnt;
      we_d       = we_q;
      be_d       = be_q;
      hold_be_d  = hold_be_q;
      hold_bit_d = hold_bit_q;

      case (state_q)
         IDLE: begin
            if (clr_start_i) begin
               base_d  = clr_base_i[ADDR_WIDTH-1:OFF_W];
               words_d = clr_words_i;
               cnt_d   = '0;
               state_d = (clr_words_i != '0) ? CLEAR : DONE;
            end
         end
         CLEAR: begin
            if (cnt_q == words_q - CNT_WIDTH'(1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (gnt) begin
         we_d = we_i;
         be_d = be_i;
      end
      if (pend_q) begin
         hold_be_d  = resp_be;
         hold_bit_d = |resp_be;
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         words_q    <= '0;
         base_q     <= '0;
         pend_q     <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         hold_be_q  <= '0;
         hold_bit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         words_q    <= words_d;
         base_q     <= base_d;
         pend_q     <= pend_d;
         we_q       <= we_d;
         be_q       <= be_d;
         hold_be_q  <= hold_be_d;
         hold_bit_q <= hold_bit_d;
      end
   end

   // Read data from the RAM arrives exactly in the response cycle; otherwise hold.
   assign gnt_o      = gnt;
   assign rvalid_o   = pend_q;
   assign rdata_be_o = pend_q ? resp_be : hold_be_q;
   assign rdata_o    = pend_q ? |resp_be : hold_bit_q;
   assign clr_busy_o = (state_q == CLEAR) || (state_q == DONE);
   assign clr_done_o = (state_q == DONE);

   always_comb begin
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_be_o    = '0;
      ram_wdata_o = 1'b0;
      if (state_q == CLEAR) begin
         ram_en_o   = 1'b1;
         ram_we_o   = 1'b1;
         ram_addr_o = {clr_word, {OFF_W{1'b0}}};
         ram_be_o   = '1;
      end else if (gnt) begin
         ram_en_o    = 1'b1;
         ram_we_o    = we_i;
         ram_addr_o  = addr_i;
         ram_be_o    = be_i;
         ram_wdata_o = wdata_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tag_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_mem_port_ctrl
// Description : Directed self-checking bench with a behavioural tag RAM.
// Revision    : 1.0
// ============================================================================
module tb_tag_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0, we = 1'b0, wdata = 1'b0, clr_start = 1'b0;
   logic [15:0] addr = '0, clr_base = '0;
   logic [3:0]  be = '0;
   logic [14:0] clr_words = '0;
   logic        gnt, rvalid, rdata, busy, done, ram_en, ram_we, ram_wdata;
   logic [3:0]  rdata_be, ram_be;
   logic [15:0] ram_addr;
   logic [3:0]  ram_rdata = '0;

   logic        mem [0:65535];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_writes = 0;

   tag_mem_port_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .CNT_WIDTH(15)) dut (
      .clk(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
      .rdata_be_o(rdata_be), .clr_start_i(clr_start), .clr_base_i(clr_base),
      .clr_words_i(clr_words), .clr_busy_o(busy), .clr_done_o(done),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_be_o(ram_be),
      .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   always #5 clk = ~clk;

   // Tag RAM model: one bit per byte, registered read.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            n_writes = n_writes + 1;
            for (int i = 0; i < 4; i++)
               if (ram_be[i]) mem[{ram_addr[15:2], 2'b00} + 16'(i)] <= ram_wdata;
         end else begin
            for (int i = 0; i < 4; i++)
               ram_rdata[i] <= mem[{ram_addr[15:2], 2'b00} + 16'(i)];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req = 1'b0; we = 1'b0; wdata = 1'b0; be = '0; addr = '0;
      clr_start = 1'b0; clr_base = '0; clr_words = '0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({gnt, rvalid, rdata, rdata_be, busy, done, ram_en, ram_we} !== 11'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %b want 0", {gnt, rvalid, rdata, rdata_be, busy, done, ram_en, ram_we});
      end
      step(); step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_write_read();
      req = 1'b1; we = 1'b1; addr = 16'h0010; be = 4'b0011; wdata = 1'b1;
      #1;
      n_cmp++;
      if ({gnt, ram_en, ram_we, ram_addr, ram_be, ram_wdata} !== {1'b1, 1'b1, 1'b1, 16'h0010, 4'b0011, 1'b1}) begin
         n_bad++; $display("FAIL wr_ram_drive: got %h want %h", {gnt, ram_en, ram_we, ram_addr, ram_be, ram_wdata}, {1'b1, 1'b1, 1'b1, 16'h0010, 4'b0011, 1'b1});
      end
      step();
      we = 1'b0; be = 4'b1111; wdata = 1'b0;
      #1;
      n_cmp++;
      if ({rvalid, rdata, rdata_be} !== 6'b1_0_0000) begin
         n_bad++; $display("FAIL wr_response: got %b want 100000", {rvalid, rdata, rdata_be});
      end
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if ({rvalid, rdata, rdata_be} !== 6'b1_1_0011) begin
         n_bad++; $display("FAIL rd_response: got %b want 110011", {rvalid, rdata, rdata_be});
      end
      step();
      n_cmp++;
      if ({rvalid, rdata, rdata_be} !== 6'b0_1_0011) begin
         n_bad++; $display("FAIL rd_hold: got %b want 010011", {rvalid, rdata, rdata_be});
      end
   endtask

   task automatic test_read_masked();
      req = 1'b1; addr = 16'h0010; be = 4'b1100;
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if ({rvalid, rdata, rdata_be} !== 6'b1_0_0000) begin
         n_bad++; $display("FAIL rd_masked: got %b want 100000", {rvalid, rdata, rdata_be});
      end
      req = 1'b1; addr = 16'h0010; be = 4'b0000;
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if ({rvalid, rdata, rdata_be} !== 6'b1_0_0000) begin
         n_bad++; $display("FAIL rd_be_zero: got %b want 100000", {rvalid, rdata, rdata_be});
      end
      step();
   endtask

   task automatic test_clear();
      logic [15:0] exp_addr [3];
      exp_addr[0] = 16'h0020; exp_addr[1] = 16'h0024; exp_addr[2] = 16'h0028;
      req = 1'b1; we = 1'b1; addr = 16'h0024; be = 4'b1111; wdata = 1'b1;
      step();
      idle_inputs();
      clr_start = 1'b1; clr_base = 16'h0020; clr_words = 15'd3;
      step();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if ({busy, done, ram_en, ram_we, ram_addr, ram_be, ram_wdata} !== {4'b1011, exp_addr[k], 4'b1111, 1'b0}) begin
            n_bad++; $display("FAIL clr_write%0d: got %h want %h", k, {busy, done, ram_en, ram_we, ram_addr, ram_be, ram_wdata}, {4'b1011, exp_addr[k], 4'b1111, 1'b0});
         end
         step();
      end
      n_cmp++;
      if ({busy, done, ram_en} !== 3'b110) begin
         n_bad++; $display("FAIL clr_done: got %b want 110", {busy, done, ram_en});
      end
      step();
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++; $display("FAIL clr_idle: got %b want 00", {busy, done});
      end
      req = 1'b1; addr = 16'h0024; be = 4'b1111;
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if ({rvalid, rdata, rdata_be} !== 6'b1_0_0000) begin
         n_bad++; $display("FAIL clr_readback: got %b want 100000", {rvalid, rdata, rdata_be});
      end
      step();
   endtask

   task automatic test_clear_wrap();
      logic [15:0] exp_addr [4];
      exp_addr[0] = 16'hFFF8; exp_addr[1] = 16'hFFFC; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0004;
      clr_start = 1'b1; clr_base = 16'hFFF8; clr_words = 15'd4;
      step();
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({ram_en, ram_we, ram_addr} !== {2'b11, exp_addr[k]}) begin
            n_bad++; $display("FAIL wrap_write%0d: got %h want %h", k, {ram_en, ram_we, ram_addr}, {2'b11, exp_addr[k]});
         end
         step();
      end
      n_cmp++;
      if ({done, ram_en} !== 2'b10) begin
         n_bad++; $display("FAIL wrap_done: got %b want 10", {done, ram_en});
      end
      step();
   endtask

   task automatic test_start_vs_req();
      clr_start = 1'b1; clr_base = 16'h0100; clr_words = 15'd1;
      req = 1'b1; we = 1'b0; addr = 16'h0010; be = 4'b1111;
      #1;
      n_cmp++;
      if ({gnt, ram_en} !== 2'b00) begin
         n_bad++; $display("FAIL start_beats_req: got %b want 00", {gnt, ram_en});
      end
      step();
      clr_start = 1'b0;
      #1;
      n_cmp++;
      if ({gnt, busy, ram_we, ram_addr} !== {3'b011, 16'h0100}) begin
         n_bad++; $display("FAIL req_blocked_clear: got %h want %h", {gnt, busy, ram_we, ram_addr}, {3'b011, 16'h0100});
      end
      step();
      n_cmp++;
      if ({gnt, done} !== 2'b01) begin
         n_bad++; $display("FAIL req_blocked_done: got %b want 01", {gnt, done});
      end
      step();
      n_cmp++;
      if ({gnt, ram_en, ram_we, ram_addr} !== {3'b110, 16'h0010}) begin
         n_bad++; $display("FAIL req_after_done: got %h want %h", {gnt, ram_en, ram_we, ram_addr}, {3'b110, 16'h0010});
      end
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if ({rvalid, rdata, rdata_be} !== 6'b1_1_0011) begin
         n_bad++; $display("FAIL req_after_done_resp: got %b want 110011", {rvalid, rdata, rdata_be});
      end
      step();
   endtask

   task automatic test_zero_words();
      int w0;
      w0 = n_writes;
      clr_start = 1'b1; clr_base = 16'h0040; clr_words = 15'd0;
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if ({busy, done, ram_en} !== 3'b110) begin
         n_bad++; $display("FAIL zero_done: got %b want 110", {busy, done, ram_en});
      end
      step();
      n_cmp++;
      if ({busy, done, n_writes - w0} !== {2'b00, 32'd0}) begin
         n_bad++; $display("FAIL zero_no_writes: busy/done %b writes %0d want 00 and 0", {busy, done}, n_writes - w0);
      end
   endtask

   task automatic test_reset_mid_clear();
      int seen_done;
      clr_start = 1'b1; clr_base = 16'h0200; clr_words = 15'd5;
      step();
      idle_inputs();
      step();
      n_cmp++;
      if (ram_addr !== 16'h0204) begin
         n_bad++; $display("FAIL midclr_2nd_word: got %h want 0204", ram_addr);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({gnt, rvalid, rdata, rdata_be, busy, done, ram_en, ram_we, ram_addr} !== 27'd0) begin
         n_bad++; $display("FAIL midclr_async_reset: got %h want 0", {gnt, rvalid, rdata, rdata_be, busy, done, ram_en, ram_we, ram_addr});
      end
      #2 rst = 1'b0;
      seen_done = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (done || busy) seen_done++;
      end
      n_cmp++;
      if (seen_done !== 0) begin
         n_bad++; $display("FAIL midclr_no_done: got %0d busy/done cycles want 0", seen_done);
      end
      clr_start = 1'b1; clr_base = 16'h0300; clr_words = 15'd1;
      step();
      idle_inputs();
      n_cmp++;
      if ({busy, ram_en, ram_addr} !== {2'b11, 16'h0300}) begin
         n_bad++; $display("FAIL midclr_restart: got %h want %h", {busy, ram_en, ram_addr}, {2'b11, 16'h0300});
      end
      step();
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++; $display("FAIL midclr_restart_done: got %b want 1", done);
      end
      step();
   endtask

   task automatic test_back_to_back();
      req = 1'b1; we = 1'b1; addr = 16'h0040; be = 4'b0101; wdata = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== 1'b1) begin
         n_bad++; $display("FAIL b2b_gnt0: got %b want 1", gnt);
      end
      step();
      we = 1'b0; be = 4'b1111; wdata = 1'b0;
      #1;
      n_cmp++;
      if ({gnt, rvalid, rdata_be} !== 6'b11_0000) begin
         n_bad++; $display("FAIL b2b_wr_resp: got %b want 110000", {gnt, rvalid, rdata_be});
      end
      step();
      be = 4'b0100;
      #1;
      n_cmp++;
      if ({gnt, rvalid, rdata, rdata_be} !== 7'b111_0101) begin
         n_bad++; $display("FAIL b2b_rd1_resp: got %b want 1110101", {gnt, rvalid, rdata, rdata_be});
      end
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if ({rvalid, rdata, rdata_be} !== 6'b11_0100) begin
         n_bad++; $display("FAIL b2b_rd2_resp: got %b want 110100", {rvalid, rdata, rdata_be});
      end
      step();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 1'b0;
      test_reset();
      test_write_read();
      test_read_masked();
      test_clear();
      test_clear_wrap();
      test_start_vs_req();
      test_zero_words();
      test_reset_mid_clear();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
